// File: rtl/inst_decoder_pkg.sv
// -----------------------------------------------------------------------------
// riscPkg
// Shared RV32I definitions for the decode stage, register file and ALU:
// XLEN, major opcode constants, ALU / branch operation enums, the decoded
// instruction bundles with their all-zero constants, and small decode helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package riscPkg;

  localparam int cXLEN = 32;

  // Major opcodes (inst[6:0])
  localparam logic [6:0] cOpcReg    = 7'h33;
  localparam logic [6:0] cOpcOpImm  = 7'h13;
  localparam logic [6:0] cOpcLui    = 7'h37;
  localparam logic [6:0] cOpcAuipc  = 7'h17;
  localparam logic [6:0] cOpcJal    = 7'h6F;
  localparam logic [6:0] cOpcJalr   = 7'h67;
  localparam logic [6:0] cOpcLoad   = 7'h03;
  localparam logic [6:0] cOpcStore  = 7'h23;
  localparam logic [6:0] cOpcBranch = 7'h63;

  typedef enum logic [3:0] {
    ADD  = 4'd0,
    SUB  = 4'd1,
    SLL  = 4'd2,
    SLT  = 4'd3,
    SLTU = 4'd4,
    XOR  = 4'd5,
    SRL  = 4'd6,
    SRA  = 4'd7,
    OR   = 4'd8,
    AND  = 4'd9
  } tArithType;

  typedef enum logic [2:0] {
    BEQ  = 3'd0,
    BNE  = 3'd1,
    BLT  = 3'd2,
    BGE  = 3'd3,
    BLTU = 3'd4,
    BGEU = 3'd5,
    JAL  = 3'd6,
    JALR = 3'd7
  } tBranchOp;

  // Immediate layout selected by the opcode
  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } tImmFmt;

  typedef struct packed {
    logic [4:0]       rs1Addr;
    logic [4:0]       rs2Addr;
    logic [4:0]       rdAddr;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic [6:0]       opcode;
    logic [cXLEN-1:0] imm;
    logic [cXLEN-1:0] curPc;
  } tDecodedInst;

  typedef struct packed {
    tArithType aritType;
    logic      opRs1;
    logic      opRs2;
    logic      opImm;
    logic      opPc;
    logic      opConst;
    logic      dv;
  } tDecodedReg;

  typedef struct packed {
    logic load;
    logic store;
    logic dv;
  } tDecodedMem;

  typedef struct packed {
    tBranchOp op;
    logic     dv;
  } tDecodedBranch;

  // One pipeline stage worth of decode results
  typedef struct packed {
    tDecodedInst   inst;
    tDecodedReg    regOp;
    tDecodedMem    memOp;
    tDecodedBranch brOp;
  } tDecodeStage;

  localparam tDecodedInst   cDecodedInst   = '0;
  localparam tDecodedReg    cDecodedReg    = '0;
  localparam tDecodedMem    cDecodedMem    = '0;
  localparam tDecodedBranch cDecodedBranch = '0;
  localparam tDecodeStage   cDecodeStage   = '0;

  function automatic tImmFmt immFmtOf(input logic [6:0] opc);
    case (opc)
      cOpcOpImm, cOpcJalr, cOpcLoad: return IMM_I;
      cOpcStore:                     return IMM_S;
      cOpcBranch:                    return IMM_B;
      cOpcLui, cOpcAuipc:            return IMM_U;
      cOpcJal:                       return IMM_J;
      default:                       return IMM_NONE;
    endcase
  endfunction

  // alt = f7[5] qualified by the caller (SUB only exists for register ops)
  function automatic tArithType arithOf(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    return alt ? SUB : ADD;
      3'd1:    return SLL;
      3'd2:    return SLT;
      3'd3:    return SLTU;
      3'd4:    return XOR;
      3'd5:    return alt ? SRA : SRL;
      3'd6:    return OR;
      default: return AND;
    endcase
  endfunction

  function automatic tBranchOp branchOf(input logic [2:0] f3);
    case (f3)
      3'd1:    return BNE;
      3'd4:    return BLT;
      3'd5:    return BGE;
      3'd6:    return BLTU;
      3'd7:    return BGEU;
      default: return BEQ;
    endcase
  endfunction

  // funct3 values 2 and 3 are not defined for conditional branches
  function automatic logic branchLegal(input logic [2:0] f3);
    return (f3 != 3'd2) && (f3 != 3'd3);
  endfunction

  // Kill a stage: fields keep flowing, only the valid flags drop
  function automatic tDecodeStage dropValid(input tDecodeStage s);
    tDecodeStage r;
    r          = s;
    r.regOp.dv = 1'b0;
    r.memOp.dv = 1'b0;
    r.brOp.dv  = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/inst_decoder_imm_gen.sv
// -----------------------------------------------------------------------------
// immGen
// Combinational RV32I immediate builder. Assembles and sign-extends the
// immediate for the selected instruction format; IMM_NONE yields zero.
// Ports:
//   inst_i  in  25  instruction bits [31:7] (opcode bits are not needed)
//   fmt_i   in  3   immediate format (tImmFmt)
//   imm_o   out 32  sign-extended immediate
// -----------------------------------------------------------------------------
module immGen
  import riscPkg::*;
(
  input  logic [31:7]      inst_i,
  input  tImmFmt           fmt_i,
  output logic [cXLEN-1:0] imm_o
);

  always_comb begin
    imm_o = '0;
    case (fmt_i)
      IMM_I: imm_o = {{20{inst_i[31]}}, inst_i[31:20]};
      IMM_S: imm_o = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
      IMM_B: imm_o = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25],
                      inst_i[11:8], 1'b0};
      IMM_U: imm_o = {inst_i[31:12], 12'b0};
      IMM_J: imm_o = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20],
                      inst_i[30:21], 1'b0};
      default: imm_o = '0;
    endcase
  end

endmodule

// File: rtl/inst_decoder.sv
// -----------------------------------------------------------------------------
// inst_decoder
// RV32I decode stage. Decodes one instruction per clock combinationally into
// stage 1, then delays the result through cycleNum-1 further struct registers
// so outputs line up with register-file read data.
//
// Flow control: there is no handshake. An instruction enters every cycle; the
// OpDv / MemDv / BrDv flags are the only qualifiers, and consumers must ignore
// the field outputs whenever the relevant flag is low.
//
// Ports:
//   iClk, iRst          clock (rising) / async active-high reset
//   iInst, iCurPC       instruction word and its PC
//   iFlushPipe          clears all valid flags (including this cycle's input)
//   oRs1Addr/oRs2Addr/oRdAddr, oF3, oF7, oOpcode   raw field extracts
//   oImm                sign-extended immediate (0 for R-type / unknown)
//   oCurPc              delayed PC
//   oLoad/oStore/oMemDv memory op bundle
//   oAritType, oOpRs1/oOpRs2/oOpImm/oOpPc/oOpConst, oOpDv   register op bundle
//   oBrOp, oBrDv        branch op bundle
// -----------------------------------------------------------------------------
module inst_decoder
  import riscPkg::*;
#(
  parameter int cycleNum = 2
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [31:0]      iInst,
  input  logic [31:0]      iCurPC,
  input  logic             iFlushPipe,
  output logic [4:0]       oRs1Addr,
  output logic [4:0]       oRs2Addr,
  output logic [4:0]       oRdAddr,
  output logic [2:0]       oF3,
  output logic [6:0]       oF7,
  output logic [6:0]       oOpcode,
  output logic [31:0]      oImm,
  output logic [31:0]      oCurPc,
  output logic             oLoad,
  output logic             oStore,
  output logic             oMemDv,
  output logic [3:0]       oAritType,
  output logic             oOpRs1,
  output logic             oOpRs2,
  output logic             oOpImm,
  output logic             oOpPc,
  output logic             oOpConst,
  output logic             oOpDv,
  output logic [2:0]       oBrOp,
  output logic             oBrDv
);

  logic [2:0]       f3;
  logic [cXLEN-1:0] imm;
  tDecodeStage      dec;
  tDecodeStage      stage_d [cycleNum];
  tDecodeStage      stage_q [cycleNum];
  tDecodeStage      out_stage;

  assign f3 = iInst[14:12];

  immGen u_imm_gen (
    .inst_i (iInst[31:7]),
    .fmt_i  (immFmtOf(iInst[6:0])),
    .imm_o  (imm)
  );

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  always_comb begin
    dec               = cDecodeStage;
    dec.inst.rs1Addr  = iInst[19:15];
    dec.inst.rs2Addr  = iInst[24:20];
    dec.inst.rdAddr   = iInst[11:7];
    dec.inst.f3       = f3;
    dec.inst.f7       = iInst[31:25];
    dec.inst.opcode   = iInst[6:0];
    dec.inst.imm      = imm;
    dec.inst.curPc    = iCurPC;

    case (iInst[6:0])
      cOpcReg: begin
        dec.regOp.opRs1    = 1'b1;
        dec.regOp.opRs2    = 1'b1;
        dec.regOp.dv       = 1'b1;
        dec.regOp.aritType = arithOf(f3, iInst[30]);
      end
      cOpcOpImm: begin
        dec.regOp.opRs1    = 1'b1;
        dec.regOp.opImm    = 1'b1;
        dec.regOp.dv       = 1'b1;
        // Immediate ops have no SUBI; f7[5] only matters for SRAI
        dec.regOp.aritType = arithOf(f3, (f3 == 3'd5) && iInst[30]);
      end
      cOpcLui: begin
        dec.regOp.opImm = 1'b1;
        dec.regOp.dv    = 1'b1;
      end
      cOpcAuipc: begin
        dec.regOp.opPc  = 1'b1;
        dec.regOp.opImm = 1'b1;
        dec.regOp.dv    = 1'b1;
      end
      cOpcJal, cOpcJalr: begin
        // Link value rd = PC + 4 is computed by the ALU
        dec.regOp.opPc    = 1'b1;
        dec.regOp.opConst = 1'b1;
        dec.regOp.dv      = 1'b1;
        dec.brOp.op       = (iInst[6:0] == cOpcJal) ? JAL : JALR;
        dec.brOp.dv       = 1'b1;
      end
      cOpcLoad: begin
        dec.memOp.load = 1'b1;
        dec.memOp.dv   = 1'b1;
      end
      cOpcStore: begin
        dec.memOp.store = 1'b1;
        dec.memOp.dv    = 1'b1;
      end
      cOpcBranch: begin
        dec.brOp.op = branchOf(f3);
        dec.brOp.dv = branchLegal(f3);
      end
      default: begin
        // Unknown opcode: fields already extracted, all valid flags stay low
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Delay pipeline: stage 0 captures the decode, later stages just shift.
  // A flush kills every stage (and the instruction being captured) at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    stage_d[0] = iFlushPipe ? dropValid(dec) : dec;
    for (int s = 1; s < cycleNum; s++) begin
      stage_d[s] = iFlushPipe ? dropValid(stage_q[s-1]) : stage_q[s-1];
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int s = 0; s < cycleNum; s++) begin
        stage_q[s] <= cDecodeStage;
      end
    end else begin
      for (int s = 0; s < cycleNum; s++) begin
        stage_q[s] <= stage_d[s];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs come straight from the last register stage
  // ---------------------------------------------------------------------------
  assign out_stage = stage_q[cycleNum-1];

  assign oRs1Addr  = out_stage.inst.rs1Addr;
  assign oRs2Addr  = out_stage.inst.rs2Addr;
  assign oRdAddr   = out_stage.inst.rdAddr;
  assign oF3       = out_stage.inst.f3;
  assign oF7       = out_stage.inst.f7;
  assign oOpcode   = out_stage.inst.opcode;
  assign oImm      = out_stage.inst.imm;
  assign oCurPc    = out_stage.inst.curPc;

  assign oLoad     = out_stage.memOp.load;
  assign oStore    = out_stage.memOp.store;
  assign oMemDv    = out_stage.memOp.dv;

  assign oAritType = out_stage.regOp.aritType;
  assign oOpRs1    = out_stage.regOp.opRs1;
  assign oOpRs2    = out_stage.regOp.opRs2;
  assign oOpImm    = out_stage.regOp.opImm;
  assign oOpPc     = out_stage.regOp.opPc;
  assign oOpConst  = out_stage.regOp.opConst;
  assign oOpDv     = out_stage.regOp.dv;

  assign oBrOp     = out_stage.brOp.op;
  assign oBrDv     = out_stage.brOp.dv;

endmodule

// File: tb/tb_inst_decoder.sv
// -----------------------------------------------------------------------------
// tb_inst_decoder
// Directed checks of the documented decode cases, flush and reset behaviour,
// followed by randomized instructions compared against a behavioural model.
// -----------------------------------------------------------------------------
module tb_inst_decoder;

  localparam int CN = 2;

  // ---------------------------------------------------------------------------
  // DUT signals
  // ---------------------------------------------------------------------------
  logic        iClk;
  logic        iRst;
  logic [31:0] iInst;
  logic [31:0] iCurPC;
  logic        iFlushPipe;
  logic [4:0]  oRs1Addr, oRs2Addr, oRdAddr;
  logic [2:0]  oF3;
  logic [6:0]  oF7, oOpcode;
  logic [31:0] oImm, oCurPc;
  logic        oLoad, oStore, oMemDv;
  logic [3:0]  oAritType;
  logic        oOpRs1, oOpRs2, oOpImm, oOpPc, oOpConst, oOpDv;
  logic [2:0]  oBrOp;
  logic        oBrDv;

  inst_decoder #(.cycleNum(CN)) dut (
    .iClk       (iClk),
    .iRst       (iRst),
    .iInst      (iInst),
    .iCurPC     (iCurPC),
    .iFlushPipe (iFlushPipe),
    .oRs1Addr   (oRs1Addr),
    .oRs2Addr   (oRs2Addr),
    .oRdAddr    (oRdAddr),
    .oF3        (oF3),
    .oF7        (oF7),
    .oOpcode    (oOpcode),
    .oImm       (oImm),
    .oCurPc     (oCurPc),
    .oLoad      (oLoad),
    .oStore     (oStore),
    .oMemDv     (oMemDv),
    .oAritType  (oAritType),
    .oOpRs1     (oOpRs1),
    .oOpRs2     (oOpRs2),
    .oOpImm     (oOpImm),
    .oOpPc      (oOpPc),
    .oOpConst   (oOpConst),
    .oOpDv      (oOpDv),
    .oBrOp      (oBrOp),
    .oBrDv      (oBrDv)
  );

  // ---------------------------------------------------------------------------
  // Clock
  // ---------------------------------------------------------------------------
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [6:0]  opc;
    logic [31:0] imm;
    logic [31:0] pc;
    logic        load;
    logic        store;
    logic        memdv;
    logic [3:0]  arit;
    logic        oprs1;
    logic        oprs2;
    logic        opimm;
    logic        oppc;
    logic        opconst;
    logic        opdv;
    logic [2:0]  brop;
    logic        brdv;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  // ALU op code per funct3 (ADD,SLL,SLT,SLTU,XOR,SRL,OR,AND); SUB=1, SRA=7
  int         arith_by_f3 [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
  // Branch op code per funct3; -1 marks an undefined branch
  int         br_by_f3    [8] = '{0, 1, -1, -1, 2, 3, 4, 5};
  logic [6:0] legal_opc   [9] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F,
                                  7'h67, 7'h03, 7'h23, 7'h63};
  logic [6:0] bad_opc     [5] = '{7'h7F, 7'h0B, 7'h0F, 7'h73, 7'h00};

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
    exp_t e;
    int   f3;
    int   sgn12;
    int   imm_i;
    e      = '0;
    e.rs1  = i[19:15];
    e.rs2  = i[24:20];
    e.rd   = i[11:7];
    e.f3   = i[14:12];
    e.f7   = i[31:25];
    e.opc  = i[6:0];
    e.pc   = pc;
    f3     = int'(i[14:12]);
    sgn12  = i[31] ? 4096 : 0;
    imm_i  = int'(i[31:20]) - sgn12;
    case (i[6:0])
      7'h33: begin
        e.oprs1 = 1'b1; e.oprs2 = 1'b1; e.opdv = 1'b1;
        e.arit  = 4'(arith_by_f3[f3]);
        if (i[30] && f3 == 0) e.arit = 4'd1;
        if (i[30] && f3 == 5) e.arit = 4'd7;
      end
      7'h13: begin
        e.oprs1 = 1'b1; e.opimm = 1'b1; e.opdv = 1'b1;
        e.arit  = 4'(arith_by_f3[f3]);
        if (i[30] && f3 == 5) e.arit = 4'd7;
        e.imm   = 32'(imm_i);
      end
      7'h37: begin
        e.opimm = 1'b1; e.opdv = 1'b1;
        e.imm   = i & 32'hFFFF_F000;
      end
      7'h17: begin
        e.oppc = 1'b1; e.opimm = 1'b1; e.opdv = 1'b1;
        e.imm  = i & 32'hFFFF_F000;
      end
      7'h6F: begin
        e.oppc = 1'b1; e.opconst = 1'b1; e.opdv = 1'b1;
        e.brop = 3'd6; e.brdv = 1'b1;
        e.imm  = 32'(int'(i[19:12]) * 4096 + int'(i[20]) * 2048 +
                     int'(i[30:21]) * 2 - (i[31] ? 1048576 : 0));
      end
      7'h67: begin
        e.oppc = 1'b1; e.opconst = 1'b1; e.opdv = 1'b1;
        e.brop = 3'd7; e.brdv = 1'b1;
        e.imm  = 32'(imm_i);
      end
      7'h03: begin
        e.load = 1'b1; e.memdv = 1'b1;
        e.imm  = 32'(imm_i);
      end
      7'h23: begin
        e.store = 1'b1; e.memdv = 1'b1;
        e.imm   = 32'(int'(i[31:25]) * 32 + int'(i[11:7]) - sgn12);
      end
      7'h63: begin
        if (br_by_f3[f3] >= 0) begin
          e.brop = 3'(br_by_f3[f3]);
          e.brdv = 1'b1;
        end
        e.imm = 32'(int'(i[7]) * 2048 + int'(i[30:25]) * 32 +
                    int'(i[11:8]) * 2 - sgn12);
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t clear_dv(input exp_t e);
    exp_t r;
    r       = e;
    r.opdv  = 1'b0;
    r.memdv = 1'b0;
    r.brdv  = 1'b0;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input string ctx, input exp_t e);
    chk({ctx, ".rs1"},     32'(oRs1Addr),  32'(e.rs1));
    chk({ctx, ".rs2"},     32'(oRs2Addr),  32'(e.rs2));
    chk({ctx, ".rd"},      32'(oRdAddr),   32'(e.rd));
    chk({ctx, ".f3"},      32'(oF3),       32'(e.f3));
    chk({ctx, ".f7"},      32'(oF7),       32'(e.f7));
    chk({ctx, ".opcode"},  32'(oOpcode),   32'(e.opc));
    chk({ctx, ".imm"},     oImm,           e.imm);
    chk({ctx, ".pc"},      oCurPc,         e.pc);
    chk({ctx, ".load"},    32'(oLoad),     32'(e.load));
    chk({ctx, ".store"},   32'(oStore),    32'(e.store));
    chk({ctx, ".memdv"},   32'(oMemDv),    32'(e.memdv));
    chk({ctx, ".arit"},    32'(oAritType), 32'(e.arit));
    chk({ctx, ".oprs1"},   32'(oOpRs1),    32'(e.oprs1));
    chk({ctx, ".oprs2"},   32'(oOpRs2),    32'(e.oprs2));
    chk({ctx, ".opimm"},   32'(oOpImm),    32'(e.opimm));
    chk({ctx, ".oppc"},    32'(oOpPc),     32'(e.oppc));
    chk({ctx, ".opconst"}, 32'(oOpConst),  32'(e.opconst));
    chk({ctx, ".opdv"},    32'(oOpDv),     32'(e.opdv));
    chk({ctx, ".brop"},    32'(oBrOp),     32'(e.brop));
    chk({ctx, ".brdv"},    32'(oBrDv),     32'(e.brdv));
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Present one instruction and wait until it has reached the outputs
  task automatic drive_wait(input logic [31:0] inst, input logic [31:0] pc);
    iInst      = inst;
    iCurPC     = pc;
    iFlushPipe = 1'b0;
    repeat (CN) @(posedge iClk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] r;
    int          pick;
    logic        flush;
    exp_t        e;

    iRst       = 1'b1;
    iInst      = '0;
    iCurPC     = '0;
    iFlushPipe = 1'b0;

    // Reset state while reset is held
    #20;
    check_outputs("rst", '0);
    #980;
    @(posedge iClk); #1;
    iRst = 1'b0;

    // ADDI x0,x0,0
    drive_wait(32'h0000_0013, 32'h0000_0000);
    chk("addi.oprs1", 32'(oOpRs1),    32'd1);
    chk("addi.opimm", 32'(oOpImm),    32'd1);
    chk("addi.opdv",  32'(oOpDv),     32'd1);
    chk("addi.imm",   oImm,           32'd0);
    chk("addi.arit",  32'(oAritType), 32'd0);
    check_outputs("addi", model(32'h0000_0013, 32'h0));

    // SUB x10,x10,x11
    drive_wait(32'h40B5_0533, 32'h0000_0004);
    chk("sub.rs1",   32'(oRs1Addr),  32'd10);
    chk("sub.rs2",   32'(oRs2Addr),  32'd11);
    chk("sub.rd",    32'(oRdAddr),   32'd10);
    chk("sub.f7",    32'(oF7),       32'h20);
    chk("sub.arit",  32'(oAritType), 32'd1);
    chk("sub.oprs1", 32'(oOpRs1),    32'd1);
    chk("sub.oprs2", 32'(oOpRs2),    32'd1);
    check_outputs("sub", model(32'h40B5_0533, 32'h4));

    // BEQ x0,x0,-4
    drive_wait(32'hFE00_0EE3, 32'h0000_0008);
    chk("beq.imm",  oImm,        32'hFFFF_FFFC);
    chk("beq.brop", 32'(oBrOp),  32'd0);
    chk("beq.brdv", 32'(oBrDv),  32'd1);
    chk("beq.opdv", 32'(oOpDv),  32'd0);
    check_outputs("beq", model(32'hFE00_0EE3, 32'h8));

    // JAL x1,8 at PC 0x100
    drive_wait(32'h0080_00EF, 32'h0000_0100);
    chk("jal.imm",     oImm,          32'd8);
    chk("jal.pc",      oCurPc,        32'h100);
    chk("jal.oppc",    32'(oOpPc),    32'd1);
    chk("jal.opconst", 32'(oOpConst), 32'd1);
    chk("jal.brop",    32'(oBrOp),    32'd6);
    check_outputs("jal", model(32'h0080_00EF, 32'h100));

    // LW followed back-to-back by SW
    iInst = 32'hFFF1_2083; iCurPC = 32'h200;
    @(posedge iClk); #1;
    iInst = 32'h0011_2223; iCurPC = 32'h204;
    @(posedge iClk); #1;
    chk("lw.imm",   oImm,         32'hFFFF_FFFF);
    chk("lw.load",  32'(oLoad),   32'd1);
    chk("lw.memdv", 32'(oMemDv),  32'd1);
    check_outputs("lw", model(32'hFFF1_2083, 32'h200));
    @(posedge iClk); #1;
    chk("sw.imm",   oImm,         32'd4);
    chk("sw.store", 32'(oStore),  32'd1);
    chk("sw.memdv", 32'(oMemDv),  32'd1);
    check_outputs("sw", model(32'h0011_2223, 32'h204));

    // Unknown opcode
    drive_wait(32'h0000_007F, 32'h0000_0300);
    chk("ill.opdv",  32'(oOpDv),  32'd0);
    chk("ill.memdv", 32'(oMemDv), 32'd0);
    chk("ill.brdv",  32'(oBrDv),  32'd0);
    chk("ill.imm",   oImm,        32'd0);

    // Flush with two valid instructions in flight
    iInst = 32'h0000_0013; iCurPC = 32'h400;
    @(posedge iClk); #1;
    iInst = 32'h40B5_0533; iCurPC = 32'h404; iFlushPipe = 1'b1;
    @(posedge iClk); #1;
    iInst = 32'h0000_0000; iCurPC = 32'h0; iFlushPipe = 1'b0;
    chk("fl1.opdv",   32'(oOpDv),   32'd0);
    chk("fl1.brdv",   32'(oBrDv),   32'd0);
    chk("fl1.memdv",  32'(oMemDv),  32'd0);
    chk("fl1.opcode", 32'(oOpcode), 32'h13);
    @(posedge iClk); #1;
    chk("fl2.opdv",   32'(oOpDv),    32'd0);
    chk("fl2.rs1",    32'(oRs1Addr), 32'd10);
    chk("fl2.pc",     oCurPc,        32'h404);

    // Asynchronous reset with a valid instruction on the outputs
    drive_wait(32'h0000_0013, 32'h0000_1234);
    chk("prerst.opdv", 32'(oOpDv), 32'd1);
    chk("prerst.pc",   oCurPc,     32'h1234);
    #2 iRst = 1'b1;
    #1;
    check_outputs("arst", '0);
    @(posedge iClk); #1;
    iRst   = 1'b0;
    iInst  = 32'h0000_0013;
    iCurPC = 32'h40;
    @(posedge iClk); #1;
    chk("bubble.opdv", 32'(oOpDv), 32'd0);
    chk("bubble.pc",   oCurPc,     32'd0);
    @(posedge iClk); #1;
    chk("postrst.opdv", 32'(oOpDv), 32'd1);
    chk("postrst.pc",   oCurPc,     32'h40);

    // Randomized phase: settle the pipeline to all-zero records first
    iInst = '0; iCurPC = '0; iFlushPipe = 1'b0;
    repeat (CN) @(posedge iClk);
    for (int k = 0; k < CN - 1; k++) exp_q.push_back(model(32'h0, 32'h0));

    for (int n = 0; n < 2000 + CN; n++) begin
      @(posedge iClk); #1;
      if (exp_q.size() == CN) check_outputs("rnd", exp_q.pop_front());
      if (n < 2000) begin
        r    = $urandom();
        pick = $urandom_range(0, 19);
        if (pick < 18) r[6:0] = legal_opc[pick % 9];
        else           r[6:0] = bad_opc[$urandom_range(0, 4)];
        flush = ($urandom_range(0, 39) == 0);
      end else begin
        r     = '0;
        flush = 1'b0;
      end
      iInst      = r;
      iCurPC     = $urandom();
      iFlushPipe = flush;
      e = model(r, iCurPC);
      if (flush) begin
        foreach (exp_q[k]) exp_q[k] = clear_dv(exp_q[k]);
        e = clear_dv(e);
      end
      exp_q.push_back(e);
    end
    iFlushPipe = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
